apb_timer_slave: RTL
====================

// Module: apb_timer_slave
// PURPOSE
//  APB2 peripheral hung off the bridge's APB side (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA out).
//  Holds a 32-bit prescaled down-counter timer with one-shot/periodic modes and a level interrupt.
//  Zero-wait-state slave; gives the bridge a real register target for read/write transfers.
// PARAMETERS
//  CNT_W    32  width of LOAD/VALUE counter (<= 32)
//  PRESC_W  8   width of PRESCALE register
// PORTS
//  BCLK     in   1   clock; all state on rising edge
//  BRESETn  in   1   asynchronous active-low reset
//  PSEL     in   1   slave select from bridge
//  PENABLE  in   1   APB access phase
//  PWRITE   in   1   1=write, 0=read
//  PADDR    in   32  byte address; only PADDR[4:2] decoded
//  PWDATA   in   32  write data
//  PRDATA   out  32  read data
//  TIMER_IRQ out 1   interrupt, level, = STATUS.INT & CTRL.IE
// BEHAVIOUR
//  Register map (offset): 0x00 CTRL [0]EN [1]PERIODIC [2]IE; 0x04 LOAD; 0x08 VALUE (RO);
//   0x0C STATUS [0]INT, write-1-to-clear; 0x10 PRESCALE. Other offsets: read 0, write ignored.
//  Reset: CTRL=0, LOAD=0, VALUE=0, STATUS=0, PRESCALE=0, prescale count=0, PRDATA=0, TIMER_IRQ=0.
//  APB tracker FSM: IDLE -> SETUP (PSEL&!PENABLE) -> ACCESS (PSEL&PENABLE) -> SETUP if PSEL&!PENABLE
//   else IDLE. PENABLE without prior SETUP is ignored (no write, PRDATA=0).
//  Write commits at the BCLK edge ending a valid ACCESS cycle with PWRITE=1; one write per transfer.
//  Read: PRDATA combinational from decoded register while PSEL&!PWRITE, else 0; zero-extend narrow regs.
//  Bits above a register's width: written ignored, read 0. VALUE write ignored.
//  Prescaler: pcnt counts 0..PRESCALE while EN=1; tick when pcnt==PRESCALE, then pcnt<=0.
//   PRESCALE=0 -> tick every cycle. EN=0 holds pcnt at 0 and VALUE frozen.
//  On tick: VALUE!=0 -> VALUE<=VALUE-1. VALUE==0 -> INT<=1; PERIODIC ? VALUE<=LOAD : EN<=0.
//   So period = (LOAD+1)*(PRESCALE+1) cycles; first INT that many cycles after EN set.
//  Write to LOAD also loads VALUE<=PWDATA[CNT_W-1:0] and clears pcnt.
//  CTRL write with EN 0->1 clears pcnt; VALUE untouched.
//  Simultaneous events, same edge:
//   - LOAD write vs tick: write wins for VALUE; INT may still set if old VALUE was 0.
//   - STATUS W1C vs INT set: set wins (INT stays 1).
//   - CTRL write vs one-shot EN auto-clear: CTRL write wins.
//  VALUE never wraps below 0; LOAD=0 periodic -> INT every (PRESCALE+1) cycles.
//  BRESETn asserted mid-transfer or mid-count: all state to reset values immediately; no partial write.
// TESTING
//  1 Reset: BRESETn=0 then read all 5 regs -> every read 0, TIMER_IRQ=0.
//  2 R/W: write LOAD=0x0000_0010, PRESCALE=0xFF_FF -> read LOAD=0x10, PRESCALE=0xFF, VALUE=0x10, 0x14 reads 0.
//  3 One-shot: LOAD=3, PRESCALE=1, CTRL=0x5 -> INT and TIMER_IRQ rise 8 cycles after CTRL write; EN reads 0.
//  4 Periodic: LOAD=2, PRESCALE=0, CTRL=0x3 -> INT set every 3 cycles; VALUE sequence 2,1,0,2; IRQ stays 0 (IE=0).
//  5 Collision: issue STATUS W1C on the same edge INT sets -> INT reads 1; next W1C clears it to 0.
//  6 Protocol: PENABLE=1 without SETUP, PWRITE=1 to LOAD -> LOAD unchanged; reset mid-ACCESS -> LOAD=0.

Source files
------------

// File: rtl/apb_timer_slave.sv
// APB2 zero-wait-state timer peripheral: prescaled 32-bit down-counter,
// one-shot/periodic modes, W1C status and level interrupt.
module apb_timer_slave #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        BCLK,
  input  logic        BRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        TIMER_IRQ
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_state_e;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_LOAD     = 3'd1;
  localparam logic [2:0] A_VALUE    = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_PRESCALE = 3'd4;

  apb_state_e         state_q, state_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   value_q, value_d;
  logic               int_q, int_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  logic [2:0] reg_sel;
  logic       wr_en;
  logic       rd_en;
  logic       tick;
  logic       unused_addr;

  assign reg_sel     = PADDR[4:2];
  assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};

  // Only the first cycle of PSEL&PENABLE following a setup phase is a real access.
  assign wr_en = PSEL && PENABLE && PWRITE && (state_q == ST_SETUP);
  assign rd_en = PSEL && !PWRITE && (!PENABLE || (state_q == ST_SETUP));
  assign tick  = ctrl_q[0] && (pcnt_q == presc_q);

  always_comb begin
    state_d = ST_IDLE;
    if (PSEL && !PENABLE) begin
      state_d = ST_SETUP;
    end else if (PSEL && PENABLE && (state_q == ST_SETUP)) begin
      state_d = ST_ACCESS;
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    value_d = value_q;
    int_d   = int_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;

    if (!ctrl_q[0] || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end

    if (tick) begin
      if (value_q != '0) begin
        value_d = value_q - CNT_W'(1);
      end else if (ctrl_q[1]) begin
        value_d = load_q;
      end else begin
        ctrl_d[0] = 1'b0;
      end
    end

    // Bus writes are applied after the counter update so they take priority.
    if (wr_en) begin
      unique case (reg_sel)
        A_CTRL: begin
          ctrl_d = PWDATA[2:0];
          if (!(ctrl_q[0] && PWDATA[0])) begin
            pcnt_d = '0;
          end
        end
        A_LOAD: begin
          load_d  = PWDATA[CNT_W-1:0];
          value_d = PWDATA[CNT_W-1:0];
          pcnt_d  = '0;
        end
        A_STATUS: begin
          if (PWDATA[0]) begin
            int_d = 1'b0;
          end
        end
        A_PRESCALE: presc_d = PWDATA[PRESC_W-1:0];
        default: ;
      endcase
    end

    if (tick && (value_q == '0)) begin
      int_d = 1'b1;
    end
  end

  always_ff @(posedge BCLK or negedge BRESETn) begin
    if (!BRESETn) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      load_q  <= '0;
      value_q <= '0;
      int_q   <= 1'b0;
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      value_q <= value_d;
      int_q   <= int_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      unique case (reg_sel)
        A_CTRL:     PRDATA = 32'(ctrl_q);
        A_LOAD:     PRDATA = 32'(load_q);
        A_VALUE:    PRDATA = 32'(value_q);
        A_STATUS:   PRDATA = 32'(int_q);
        A_PRESCALE: PRDATA = 32'(presc_q);
        default:    PRDATA = '0;
      endcase
    end
  end

  assign TIMER_IRQ = int_q && ctrl_q[2];

endmodule
